// File: rtl/mips_shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: ALU control codes, FSM states, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_shift_sequencer_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int SHAMT_WIDTH_DEF = 5;

    // ALU control codes understood by the MIPS ALU this block drives.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL1 = 4'b1000;
    localparam logic [3:0] ALU_SRL1 = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Single-bit shift opcode for the requested direction (0 = left, 1 = right).
    function automatic logic [3:0] shift_code(input logic op);
        return op ? ALU_SRL1 : ALU_SLL1;
    endfunction

endpackage

// File: rtl/mips_shift_sequencer_if.sv
// Request/result and ALU-facing signal bundle of the shift sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start_in is ignored while the sequencer is busy.
interface mips_shift_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   start_in;
    logic                   op_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [SHAMT_WIDTH-1:0] shamt_in;
    logic                   busy_out;
    logic                   done_out;
    logic [DATA_WIDTH-1:0]  result_out;
    logic                   zero_out;
    logic [3:0]             alu_cntrl_out;
    logic [DATA_WIDTH-1:0]  alu_a_out;
    logic [DATA_WIDTH-1:0]  alu_b_out;
    logic [DATA_WIDTH-1:0]  alu_result_in;
    logic                   alu_zero_in;

    // Control unit / ALU side: issues requests and returns ALU results.
    modport master (
        output start_in, op_in, data_in, shamt_in, alu_result_in, alu_zero_in,
        input  busy_out, done_out, result_out, zero_out,
               alu_cntrl_out, alu_a_out, alu_b_out
    );

    // Sequencer side.
    modport slave (
        input  start_in, op_in, data_in, shamt_in, alu_result_in, alu_zero_in,
        output busy_out, done_out, result_out, zero_out,
               alu_cntrl_out, alu_a_out, alu_b_out
    );
endinterface

// File: rtl/mips_shift_sequencer.sv
// Variable-amount logical shifter built from repeated ALU shift-by-1 operations.
// Latency: shamt+1 cycles from accepting edge to done_out (1 cycle for shamt 0).
// Backpressure: start_in ignored while busy; accepted in IDLE or in the DONE cycle.
module mips_shift_sequencer
    import mips_shift_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_shift_sequencer_if.slave bus
);

    state_e                 state_q,  state_d;
    logic [DATA_WIDTH-1:0]  work_q,   work_d;
    logic [SHAMT_WIDTH-1:0] count_q,  count_d;
    logic                   op_q,     op_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q,   zero_d;
    logic [3:0]             cntrl_q,  cntrl_d;
    logic [DATA_WIDTH-1:0]  alu_b_q,  alu_b_d;

    // Next-state and next-output computation; every output is then registered.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start_in) begin
                    work_d  = bus.data_in;
                    count_d = bus.shamt_in;
                    op_d    = bus.op_in;
                    if (bus.shamt_in != '0) begin
                        state_d = SHIFT;
                    end else begin
                        // Zero shift bypasses the ALU entirely.
                        state_d  = DONE;
                        result_d = bus.data_in;
                        zero_d   = (bus.data_in == '0);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // The ALU result of this cycle is the operand for the next one.
                work_d  = bus.alu_result_in;
                count_d = count_q - SHAMT_WIDTH'(1);
                if (count_q == SHAMT_WIDTH'(1)) begin
                    state_d  = DONE;
                    result_d = bus.alu_result_in;
                    zero_d   = bus.alu_zero_in;
                end
            end
            default: state_d = IDLE;
        endcase

        // ALU drives follow the next state so they are aligned with the registered state.
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
        cntrl_d = busy_d ? shift_code(op_d) : ALU_AND;
        alu_b_d = busy_d ? work_d : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cntrl_q  <= ALU_AND;
            alu_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cntrl_q  <= cntrl_d;
            alu_b_q  <= alu_b_d;
        end
    end

    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.result_out    = result_q;
    assign bus.zero_out      = zero_q;
    assign bus.alu_cntrl_out = cntrl_q;
    assign bus.alu_a_out     = '0;
    assign bus.alu_b_out     = alu_b_q;

endmodule

// File: tb/tb_mips_shift_sequencer.sv
// Self-checking bench for mips_shift_sequencer with a behavioural ALU alongside it.
// Latency: checks shamt+1 cycle done timing against a shift-operator reference.
// Backpressure: exercises start-while-busy, back-to-back starts and mid-operation reset.
module tb_mips_shift_sequencer;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    mips_shift_sequencer_if bus ();

    mips_shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Environment ALU: purely combinational model of the MIPS ALU.
    always_comb begin
        logic [31:0] r;
        case (bus.alu_cntrl_out)
            4'b0000: r = bus.alu_a_out & bus.alu_b_out;
            4'b0001: r = bus.alu_a_out | bus.alu_b_out;
            4'b0010: r = bus.alu_a_out + bus.alu_b_out;
            4'b0110: r = bus.alu_a_out - bus.alu_b_out;
            4'b0111: r = {31'b0, $signed(bus.alu_a_out) < $signed(bus.alu_b_out)};
            4'b1000: r = bus.alu_b_out << 1;
            4'b1001: r = bus.alu_b_out >> 1;
            4'b1100: r = ~(bus.alu_a_out | bus.alu_b_out);
            4'b1111: r = {bus.alu_b_out[15:0], 16'h0000};
            default: r = 32'h0;
        endcase
        bus.alu_result_in = r;
        bus.alu_zero_in   = (r == 32'h0);
    end

    // Reference: a logical shift by shamt, vacated bits zero.
    function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input int sh);
        return op ? (d >> sh) : (d << sh);
    endfunction

    task automatic drive_start(input logic op, input logic [31:0] data, input logic [4:0] sh);
        bus.op_in    = op;
        bus.data_in  = data;
        bus.shamt_in = sh;
        bus.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
    endtask

    // Observes cycles until done_out; counts busy cycles and ALU drive deviations.
    task automatic wait_done(input logic op, input logic [31:0] data,
                             output int lat, output int busy_n,
                             output int drive_err, output bit timed_out);
        logic [3:0] code;
        code      = op ? 4'b1001 : 4'b1000;
        lat       = 0;
        busy_n    = 0;
        drive_err = 0;
        timed_out = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            lat = k;
            if (bus.busy_out) begin
                if (bus.alu_cntrl_out !== code || bus.alu_a_out !== 32'h0 ||
                    bus.alu_b_out !== ref_shift(op, data, busy_n))
                    drive_err++;
                busy_n++;
            end else if (bus.alu_cntrl_out !== 4'b0000 || bus.alu_a_out !== 32'h0 ||
                         bus.alu_b_out !== 32'h0) begin
                drive_err++;
            end
            if (bus.done_out) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.busy_out, bus.done_out, bus.zero_out} !== 3'b000) begin
                $display("FAIL reset_flags cycle %0d: got %b want 000", c,
                         {bus.busy_out, bus.done_out, bus.zero_out});
            end else pass_cnt++;
            total_cnt++;
            if (bus.result_out !== 32'h0) begin
                $display("FAIL reset_result: got %h want 0", bus.result_out);
            end else pass_cnt++;
            total_cnt++;
            if (bus.alu_cntrl_out !== 4'b0000 || bus.alu_a_out !== 32'h0 || bus.alu_b_out !== 32'h0) begin
                $display("FAIL reset_alu: cntrl %b a %h b %h want 0", bus.alu_cntrl_out,
                         bus.alu_a_out, bus.alu_b_out);
            end else pass_cnt++;
        end
    endtask

    task automatic test_sll_basic;
        int lat, busy_n, derr;
        bit to;
        @(negedge clk);
        drive_start(1'b0, 32'h0000_0001, 5'd4);
        wait_done(1'b0, 32'h0000_0001, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 5) $display("FAIL sll_latency: got %0d (timeout %0d) want 5", lat, to);
        else pass_cnt++;
        total_cnt++;
        if (busy_n != 4 || derr != 0) $display("FAIL sll_busy_drive: busy %0d err %0d want 4/0", busy_n, derr);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_out !== 32'h10 || bus.zero_out !== 1'b0)
            $display("FAIL sll_result: got %h z%b want 00000010 z0", bus.result_out, bus.zero_out);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.done_out !== 1'b0 || bus.result_out !== 32'h10)
            $display("FAIL sll_done_pulse: done %b result %h want 0/00000010", bus.done_out, bus.result_out);
        else pass_cnt++;
    endtask

    task automatic test_srl_max;
        int lat, busy_n, derr;
        bit to;
        drive_start(1'b1, 32'h8000_0000, 5'd31);
        wait_done(1'b1, 32'h8000_0000, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 32 || busy_n != 31 || derr != 0)
            $display("FAIL srl31_timing: lat %0d busy %0d err %0d want 32/31/0", lat, busy_n, derr);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_out !== 32'h1 || bus.zero_out !== 1'b0)
            $display("FAIL srl31_result: got %h z%b want 00000001 z0", bus.result_out, bus.zero_out);
        else pass_cnt++;
        @(negedge clk);
        drive_start(1'b0, 32'h8000_0000, 5'd1);
        wait_done(1'b0, 32'h8000_0000, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 2 || bus.result_out !== 32'h0 || bus.zero_out !== 1'b1)
            $display("FAIL sll_overflow: lat %0d got %h z%b want 2 00000000 z1", lat,
                     bus.result_out, bus.zero_out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat, busy_n, derr;
        bit to;
        @(negedge clk);
        drive_start(1'b0, 32'hDEAD_BEEF, 5'd0);
        wait_done(1'b0, 32'hDEAD_BEEF, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 1 || busy_n != 0)
            $display("FAIL zero_shamt_timing: lat %0d busy %0d want 1/0", lat, busy_n);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_out !== 32'hDEAD_BEEF || bus.zero_out !== 1'b0)
            $display("FAIL zero_shamt_result: got %h z%b want deadbeef z0", bus.result_out, bus.zero_out);
        else pass_cnt++;
        // Next request issued during the DONE cycle.
        drive_start(1'b1, 32'hDEAD_BEEF, 5'd2);
        wait_done(1'b1, 32'hDEAD_BEEF, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 3 || busy_n != 2 || derr != 0 || bus.result_out !== 32'h37AB_6FBB)
            $display("FAIL b2b_srl2: lat %0d busy %0d err %0d got %h want 3/2/0 37ab6fbb",
                     lat, busy_n, derr, bus.result_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        int lat, busy_n, derr, dones;
        bit to;
        @(negedge clk);
        drive_start(1'b0, 32'h0000_1234, 5'd10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0 || bus.result_out !== 32'h0 ||
            bus.zero_out !== 1'b0 || bus.alu_cntrl_out !== 4'b0000)
            $display("FAIL midreset_state: busy %b done %b result %h zero %b cntrl %b want all 0",
                     bus.busy_out, bus.done_out, bus.result_out, bus.zero_out, bus.alu_cntrl_out);
        else pass_cnt++;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done_out) dones++;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL midreset_no_done: got %0d pulses want 0", dones);
        else pass_cnt++;
        drive_start(1'b0, 32'h0000_000F, 5'd2);
        wait_done(1'b0, 32'h0000_000F, lat, busy_n, derr, to);
        total_cnt++;
        if (to || lat != 3 || bus.result_out !== 32'h3C)
            $display("FAIL midreset_restart: lat %0d got %h want 3 0000003c", lat, bus.result_out);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        int lat, dones;
        @(negedge clk);
        drive_start(1'b0, 32'h0000_FFFF, 5'd8);
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 3) begin
                bus.op_in    = 1'b1;
                bus.data_in  = 32'h0000_0001;
                bus.shamt_in = 5'd1;
                bus.start_in = 1'b1;
            end
            if (k == 4) bus.start_in = 1'b0;
            if (bus.done_out) break;
        end
        total_cnt++;
        if (lat != 9 || bus.result_out !== 32'h00FF_FF00)
            $display("FAIL busy_ignore: lat %0d got %h want 9 00ffff00", lat, bus.result_out);
        else pass_cnt++;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done_out) dones++;
        end
        total_cnt++;
        if (dones != 0 || bus.result_out !== 32'h00FF_FF00)
            $display("FAIL busy_second_request: pulses %0d result %h want 0 00ffff00", dones, bus.result_out);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int lat, busy_n, derr;
        bit to;
        logic op;
        logic [31:0] data, expv;
        logic [4:0] sh;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            op   = 1'($urandom_range(1));
            sh   = 5'($urandom_range(31));
            data = (n % 7 == 0) ? 32'h0 : $urandom;
            expv = ref_shift(op, data, int'(sh));
            drive_start(op, data, sh);
            wait_done(op, data, lat, busy_n, derr, to);
            total_cnt++;
            if (to || lat != int'(sh) + 1 || busy_n != int'(sh) || derr != 0)
                $display("FAIL rand_timing #%0d: lat %0d busy %0d err %0d want %0d/%0d/0",
                         n, lat, busy_n, derr, int'(sh) + 1, int'(sh));
            else pass_cnt++;
            total_cnt++;
            if (bus.result_out !== expv || bus.zero_out !== (expv == 32'h0))
                $display("FAIL rand_result #%0d op%0d sh%0d data %h: got %h z%b want %h z%b",
                         n, op, sh, data, bus.result_out, bus.zero_out, expv, expv == 32'h0);
            else pass_cnt++;
            // Half the time issue the next request straight from the DONE cycle.
            if ($urandom_range(1) == 0) @(negedge clk);
        end
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        reset        = 1'b1;
        bus.start_in = 1'b0;
        bus.op_in    = 1'b0;
        bus.data_in  = 32'h0;
        bus.shamt_in = 5'd0;
        test_reset();
        test_sll_basic();
        test_srl_max();
        test_back_to_back();
        test_reset_mid_op();
        test_start_while_busy();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
